// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing around execute plus ALU operand forwarding selects.
// Latency: stalls, forwarding and load-use response are combinational; the branch flush starts the cycle after branch_taken_e.
// Backpressure: a data-memory wait (req & !ready) holds all four pipeline stages until ready returns.
//
// Ports: clk/rst (async, active-high); decode/execute/memory/writeback register addresses and
// write enables; mem_to_reg_e, branch_taken_e, mem_req_m/mem_ready_m in. stall_f/d/e/m,
// flush_d/e, fwd_a_e/fwd_b_e, state and the saturating stall_cycles counter out.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding. When it is not defined,
// any decode source matching a writing destination stalls instead.
module hazard_ctrl #(
  parameter int REG_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] ra1_d,
  input  logic [REG_BITS-1:0] ra2_d,
  input  logic [REG_BITS-1:0] ra1_e,
  input  logic [REG_BITS-1:0] ra2_e,
  input  logic [REG_BITS-1:0] wa_e,
  input  logic [REG_BITS-1:0] wa_m,
  input  logic [REG_BITS-1:0] wa_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                branch_taken_e,
  input  logic                mem_req_m,
  input  logic                mem_ready_m,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic [1:0]          state,
  output logic [15:0]         stall_cycles
);

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_MEM_WAIT = 2'b01;
  localparam logic [1:0] S_BR_FLUSH = 2'b10;

  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  logic [1:0]    state_q, state_nxt;
  logic          pend_q, pend_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          mem_block;
  logic          data_hazard;
  logic          s_f, s_d, s_e, s_m, f_d, f_e;

  assign mem_block = mem_req_m & ~mem_ready_m;

`ifdef HAZARD_FORWARD_EN
  // Only a load in execute cannot be forwarded in time.
  assign data_hazard = mem_to_reg_e & reg_write_e & ((wa_e == ra1_d) | (wa_e == ra2_d));

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] ra);
    if (reg_write_m && wa_m == ra)      fwd_sel = 2'b10;
    else if (reg_write_w && wa_w == ra) fwd_sel = 2'b01;
    else                                fwd_sel = 2'b00;
  endfunction

  assign fwd_a_e = rst ? 2'b00 : fwd_sel(ra1_e);
  assign fwd_b_e = rst ? 2'b00 : fwd_sel(ra2_e);
`else
  // Without forwarding, any in-flight producer of a decode source must drain first.
  assign data_hazard = (reg_write_e & ((wa_e == ra1_d) | (wa_e == ra2_d)))
                     | (reg_write_m & ((wa_m == ra1_d) | (wa_m == ra2_d)))
                     | (reg_write_w & ((wa_w == ra1_d) | (wa_w == ra2_d)));

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ra1_e, ra2_e, mem_to_reg_e};

  assign fwd_a_e = 2'b00;
  assign fwd_b_e = 2'b00;
`endif

  always_comb begin
    state_nxt = state_q;
    pend_nxt  = pend_q;
    cnt_nxt   = cnt_q;
    s_f = 1'b0; s_d = 1'b0; s_e = 1'b0; s_m = 1'b0;
    f_d = 1'b0; f_e = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_block) begin
          // Stall in the entry cycle itself; a branch seen now must survive the wait.
          {s_f, s_d, s_e, s_m} = 4'b1111;
          state_nxt = S_MEM_WAIT;
          pend_nxt  = branch_taken_e;
        end else if (branch_taken_e) begin
          state_nxt = S_BR_FLUSH;
          cnt_nxt   = CNT_LOAD;
        end else if (data_hazard) begin
          s_f = 1'b1;
          s_d = 1'b1;
          f_e = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ready_m) begin
          {s_f, s_d, s_e, s_m} = 4'b1111;
          if (branch_taken_e) pend_nxt = 1'b1;
        end else if (pend_q || branch_taken_e) begin
          state_nxt = S_BR_FLUSH;
          cnt_nxt   = CNT_LOAD;
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_BR_FLUSH: begin
        f_d = 1'b1;
        f_e = 1'b1;
        if (cnt_q == '0) state_nxt = S_RUN;
        else             cnt_nxt   = cnt_q - 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Reset must silence the combinational paths, not just the registered state.
  assign stall_f = s_f & ~rst;
  assign stall_d = s_d & ~rst;
  assign stall_e = s_e & ~rst;
  assign stall_m = s_m & ~rst;
  assign flush_d = f_d & ~rst;
  assign flush_e = f_e & ~rst;
  assign state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_nxt;
      pend_q  <= pend_nxt;
      cnt_q   <= cnt_nxt;
      if (stall_f && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle expected output vectors go into a scoreboard queue as
// stimulus is applied and are popped and compared at the following falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ra1_d = '0, ra2_d = '0, ra1_e = '0, ra2_e = '0;
  logic [3:0] wa_e = '0, wa_m = '0, wa_w = '0;
  logic       reg_write_e = 0, reg_write_m = 0, reg_write_w = 0;
  logic       mem_to_reg_e = 0, branch_taken_e = 0, mem_req_m = 0, mem_ready_m = 0;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e, state;
  logic [15:0] stall_cycles;

  hazard_ctrl #(.REG_BITS(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
    .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .branch_taken_e(branch_taken_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {stall_f,stall_d,stall_e,stall_m}, {flush_d,flush_e}, fwd_a, fwd_b, state
  typedef struct packed {
    logic [3:0] stalls;
    logic [1:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_sc  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic out_t mk(input logic [3:0] s, input logic [1:0] f,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
    out_t o;
    o.stalls = s; o.flush = f; o.fa = fa; o.fb = fb; o.st = st;
    return o;
  endfunction

  // Inputs are already applied; queue the expectation, compare at negedge, advance past posedge.
  task automatic cyc(input string tag, input out_t e);
    out_t  got, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = mk({stall_f, stall_d, stall_e, stall_m}, {flush_d, flush_e}, fwd_a_e, fwd_b_e, state);
    check(t, 32'(got), 32'(want));
    check({t, "_sc"}, 32'(stall_cycles), 32'(exp_sc));
    if (want.stalls[3] && !rst) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ra1_d = 0; ra2_d = 0; ra1_e = 0; ra2_e = 0; wa_e = 0; wa_m = 0; wa_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; branch_taken_e = 0; mem_req_m = 0; mem_ready_m = 0;
  endtask

  initial begin
    // Reset: a memory wait condition must not leak through while rst is high.
    mem_req_m = 1;
    cyc("reset", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    clear_inputs();
    rst = 0;
    cyc("idle", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    // Load-use hazard: one-cycle stall of F/D with a bubble into execute.
    mem_to_reg_e = 1; reg_write_e = 1; wa_e = 4'd3; ra2_d = 4'd3;
    cyc("load_use", mk(4'b1100, 2'b01, 2'b00, 2'b00, 2'b00));
    clear_inputs();
    cyc("load_use_done", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    check("sc_after_load_use", 32'(stall_cycles), 32'd1);

    // Forwarding: memory stage beats writeback, then writeback alone, then none.
    wa_m = 4'd5; wa_w = 4'd5; reg_write_m = 1; reg_write_w = 1; ra1_e = 4'd5; ra2_e = 4'd2;
    cyc("fwd_mem_prio", mk(4'b0000, 2'b00, FWD ? 2'b10 : 2'b00, 2'b00, 2'b00));
    reg_write_m = 0;
    cyc("fwd_wb", mk(4'b0000, 2'b00, FWD ? 2'b01 : 2'b00, 2'b00, 2'b00));
    ra1_e = 4'd1; ra2_e = 4'd5;
    cyc("fwd_b_wb", mk(4'b0000, 2'b00, 2'b00, FWD ? 2'b01 : 2'b00, 2'b00));
    reg_write_w = 0;
    cyc("fwd_none", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    // Decode source matches writeback destination (not a load): stall only without forwarding.
    reg_write_w = 1; wa_w = 4'd7; ra1_d = 4'd7;
    cyc("wb_match_d", mk(FWD ? 4'b0000 : 4'b1100, FWD ? 2'b00 : 2'b01, 2'b00, 2'b00, 2'b00));
    clear_inputs();

    // Branch: pulse before edge N, flush in N+1 and N+2, clear at N+3.
    branch_taken_e = 1;
    cyc("br_pulse", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_taken_e = 0;
    cyc("br_flush1", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("br_flush2", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("br_done", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    // Memory wait: four stalled cycles, stalls drop with ready in the same cycle.
    exp_sc = int'(stall_cycles) == exp_sc ? exp_sc : exp_sc;
    mem_req_m = 1; mem_ready_m = 0;
    cyc("mw_entry", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++)
      cyc("mw_wait", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b01));
    mem_ready_m = 1;
    cyc("mw_ready", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b01));
    clear_inputs();
    cyc("mw_run", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    // Pending branch: taken in the entry cycle, honoured only after ready.
    mem_req_m = 1; branch_taken_e = 1;
    cyc("pb_entry", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_taken_e = 0;
    cyc("pb_wait", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b01));
    mem_ready_m = 1;
    cyc("pb_ready", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b01));
    clear_inputs();
    cyc("pb_flush1", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("pb_flush2", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("pb_done", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    // Pending branch raised while already waiting.
    mem_req_m = 1;
    cyc("pw_entry", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_taken_e = 1;
    cyc("pw_wait_br", mk(4'b1111, 2'b00, 2'b00, 2'b00, 2'b01));
    branch_taken_e = 0; mem_ready_m = 1;
    cyc("pw_ready", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b01));
    clear_inputs();
    cyc("pw_flush1", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("pw_flush2", mk(4'b0000, 2'b11, 2'b00, 2'b00, 2'b10));
    cyc("pw_done", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    // Reset in the first flush cycle abandons the flush.
    branch_taken_e = 1;
    cyc("rf_pulse", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    branch_taken_e = 0;
    #1;
    check("rf_flush_before_rst", 32'({flush_d, flush_e, state}), 32'({2'b11, 2'b10}));
    rst = 1;
    exp_sc = 0;
    #1;
    check("rf_flush_in_rst", 32'({flush_d, flush_e, state}), 32'({2'b00, 2'b00}));
    cyc("rf_rst", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));
    rst = 0;
    for (int i = 0; i < 3; i++)
      cyc("rf_after", mk(4'b0000, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
